ex_branch_stage: RTL

// Pipeline stage directly downstream of the ALU. Captures the ALU result and flags
// (V,C,Z,N) together with branch info, and resolves RISC-V conditional branches

---
 rtl/ex_branch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/ex_branch_stage.sv
// Branch-resolve stage after the ALU: evaluates RISC-V branch conditions from the ALU flags,
// computes pc+imm, and forwards each beat through a 2-entry skid buffer so in_ready stays registered.
module ex_branch_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_res,
  input  logic [3:0]            in_flags,
  input  logic                  in_is_branch,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_res,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_taken,
  output logic [XLEN-1:0]       out_target,
  output logic                  out_misalign
);

  typedef struct packed {
    logic [XLEN-1:0]       res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  taken;
    logic [XLEN-1:0]       target;
    logic                  misalign;
  } beat_t;

  beat_t in_beat, main_q, skid_q;
  logic  main_vld, skid_vld;
  logic  cond, eq, lt, ltu;
  logic  accept, deliver;

  // flags: [0]=V [1]=C [2]=Z [3]=N
  assign eq  = in_flags[2];
  assign lt  = in_flags[3] ^ in_flags[0];
  assign ltu = ~in_flags[1];

  always_comb begin
    cond = 1'b0;
    case (in_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    in_beat          = '0;
    in_beat.res      = in_res;
    in_beat.rd       = in_rd;
    in_beat.taken    = in_is_branch & cond;
    in_beat.target   = in_pc + in_imm;
    in_beat.misalign = in_beat.taken & (in_beat.target[1:0] != 2'b00);
  end

  assign in_ready = ~skid_vld;
  assign accept   = in_valid & ~skid_vld;
  assign deliver  = main_vld & out_ready;

  // Main never sits empty while skid is full, so skid only refills main on delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || deliver) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= in_beat;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= in_beat;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid    = main_vld;
  assign out_res      = main_q.res;
  assign out_rd       = main_q.rd;
  assign out_taken    = main_q.taken;
  assign out_target   = main_q.target;
  assign out_misalign = main_q.misalign;

endmodule
